// File: rtl/msg_sink_if.sv
// Producer/reader handshake bundle for msg_sink: an input message channel
// (valid/ready + severity/code) and an output FIFO-head channel.
interface msg_sink_if #(
  parameter int CODE_W = 8,
  parameter int TS_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_sev;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_sev;
  logic [CODE_W-1:0] out_code;
  logic [TS_W-1:0]   out_ts;

  // Environment side: produces messages and consumes the FIFO head.
  modport master (
    output in_valid, in_sev, in_code, out_ready,
    input  in_ready, out_valid, out_sev, out_code, out_ts
  );

  // Sink side.
  modport slave (
    input  in_valid, in_sev, in_code, out_ready,
    output in_ready, out_valid, out_sev, out_code, out_ts
  );
endinterface

// File: rtl/msg_sink.sv
// msg_sink: timestamps accepted messages into a FIFO, keeps saturating
// WARN/ERROR counts and raises a sticky terminate on FATAL (or ERROR when
// term_on_err is set). Handshake readiness comes from registered state only.
module msg_sink #(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 8,
  parameter int TS_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             term_on_err,
  input  logic             clr_cnt,
  msg_sink_if.slave        bus,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] warn_cnt,
  output logic             terminate
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]      FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [1:0] SEV_WARN  = 2'd1;
  localparam logic [1:0] SEV_ERROR = 2'd2;
  localparam logic [1:0] SEV_FATAL = 2'd3;

  typedef struct packed {
    logic [1:0]        sev;
    logic [CODE_W-1:0] code;
    logic [TS_W-1:0]   ts;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]        cnt_q, cnt_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [CNT_W-1:0]   warn_q, warn_d, err_q, err_d;
  logic               term_q, term_d;

  logic   full, empty, push, pop;
  entry_t head;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign bus.in_ready  = !full && !term_q;
  assign bus.out_valid = !empty;
  assign push  = bus.in_valid && bus.in_ready;
  assign pop   = bus.out_valid && bus.out_ready;

  // Head is forced to zero while empty so the outputs read 0 out of reset.
  assign head         = mem_q[rd_ptr_q];
  assign bus.out_sev  = empty ? '0 : head.sev;
  assign bus.out_code = empty ? '0 : head.code;
  assign bus.out_ts   = empty ? '0 : head.ts;

  assign err_cnt   = err_q;
  assign warn_cnt  = warn_q;
  assign terminate = term_q;

  // Next-state: FIFO push/pop, timestamp, counters and sticky terminate.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ts_d     = ts_q + TS_W'(1);
    warn_d   = warn_q;
    err_d    = err_q;
    term_d   = term_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{sev: bus.in_sev, code: bus.in_code, ts: ts_q};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      cnt_d = cnt_q + (PW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (PW+1)'(1);

    // A clear in the same cycle as an increment wins.
    if (clr_cnt) begin
      warn_d = '0;
      err_d  = '0;
    end else if (push) begin
      if (bus.in_sev == SEV_WARN && warn_q != CNT_MAX)  warn_d = warn_q + CNT_W'(1);
      if (bus.in_sev == SEV_ERROR && err_q != CNT_MAX)  err_d  = err_q + CNT_W'(1);
    end

    if (push && (bus.in_sev == SEV_FATAL || (bus.in_sev == SEV_ERROR && term_on_err)))
      term_d = 1'b1;
  end

  // State registers; reset discards the FIFO contents immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ts_q     <= '0;
      warn_q   <= '0;
      err_q    <= '0;
      term_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ts_q     <= ts_d;
      warn_q   <= warn_d;
      err_q    <= err_d;
      term_q   <= term_d;
    end
  end
endmodule

// File: tb/tb_msg_sink.sv
// Bench for msg_sink: directed scenarios plus random traffic, every cycle
// checked against a queue-based reference model.
module tb_msg_sink;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int TW    = 32;
  localparam int NW    = 4;
  localparam int CMAX  = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          toe = 1'b0;
  logic          clr = 1'b0;
  logic [NW-1:0] err_cnt, warn_cnt;
  logic          terminate;

  msg_sink_if #(.CODE_W(CW), .TS_W(TW)) bus ();

  msg_sink #(.DEPTH(DEPTH), .CODE_W(CW), .TS_W(TW), .CNT_W(NW)) dut (
    .clk        (clk),
    .reset      (reset),
    .term_on_err(toe),
    .clr_cnt    (clr),
    .bus        (bus),
    .err_cnt    (err_cnt),
    .warn_cnt   (warn_cnt),
    .terminate  (terminate)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    sev;
    logic [CW-1:0] code;
    logic [TW-1:0] ts;
  } ent_t;

  ent_t        q[$];
  int unsigned ts_m;
  int          warn_m, err_m;
  bit          term_m;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ts_m   = 0;
    warn_m = 0;
    err_m  = 0;
    term_m = 0;
  endtask

  task automatic check_state();
    chk("in_ready", bus.in_ready, (q.size() < DEPTH) && !term_m);
    chk("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_sev", bus.out_sev, q[0].sev);
      chk("out_code", bus.out_code, q[0].code);
      chk("out_ts", bus.out_ts, q[0].ts);
    end else begin
      chk("out_zero", {bus.out_sev, bus.out_code, bus.out_ts}, 0);
    end
    chk("warn_cnt", warn_cnt, warn_m);
    chk("err_cnt", err_cnt, err_m);
    chk("terminate", terminate, term_m);
  endtask

  // One cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step(input bit v, input bit [1:0] sev, input bit [CW-1:0] code,
                      input bit ordy, input bit t, input bit c);
    bit acc, pop;
    bus.in_valid  = v;
    bus.in_sev    = sev;
    bus.in_code   = code;
    bus.out_ready = ordy;
    toe = t;
    clr = c;
    #1;
    check_state();
    acc = v && (q.size() < DEPTH) && !term_m;
    pop = (q.size() > 0) && ordy;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back('{sev, code, ts_m});
    if (c) begin
      warn_m = 0;
      err_m  = 0;
    end else if (acc) begin
      if (sev == 2'd1) warn_m = (warn_m < CMAX) ? warn_m + 1 : CMAX;
      if (sev == 2'd2) err_m  = (err_m < CMAX) ? err_m + 1 : CMAX;
    end
    if (acc && (sev == 2'd3 || (sev == 2'd2 && t))) term_m = 1;
    ts_m = ts_m + 1;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (DEPTH + 1) step(0, 0, 0, 1, 0, 0);
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_warn", warn_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_term", terminate, 0);
    chk("rst_out", {bus.out_sev, bus.out_code, bus.out_ts}, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_sev = 0; bus.in_code = 0; bus.out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("por_in_ready", bus.in_ready, 1);
    chk("por_out_valid", bus.out_valid, 0);
    chk("por_cnts", {warn_cnt, err_cnt, terminate}, 0);
    reset = 1'b0;

    // Three back-to-back messages accepted at ts 5,6,7.
    repeat (5) step(0, 0, 0, 1, 0, 0);
    step(1, 2'd0, 8'h11, 1, 0, 0);
    chk("ts5", bus.out_ts, 5);
    step(1, 2'd1, 8'h22, 1, 0, 0);
    chk("ts6", bus.out_ts, 6);
    step(1, 2'd2, 8'h33, 1, 0, 0);
    chk("ts7", bus.out_ts, 7);
    chk("code33", bus.out_code, 8'h33);
    drain();
    chk("basic_warn", warn_cnt, 1);
    chk("basic_err", err_cnt, 1);
    chk("basic_term", terminate, 0);

    // Fill past full with the reader stalled, then drain; twice for wrap.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH + 2; i++) step(1, 2'd0, 8'(8'h80 + 16*r + i), 0, 0, 0);
      chk("full_rdy", bus.in_ready, 0);
      chk("full_head", bus.out_code, 8'(8'h80 + 16*r));
      drain();
      chk("drained", bus.out_valid, 0);
    end

    // ERROR with term_on_err: terminate, message still readable.
    step(0, 0, 0, 0, 0, 1);
    step(1, 2'd2, 8'h44, 0, 1, 0);
    chk("err_term", terminate, 1);
    chk("err_rdy", bus.in_ready, 0);
    chk("err_cnt1", err_cnt, 1);
    step(1, 2'd0, 8'h99, 0, 0, 0);
    step(1, 2'd3, 8'h9a, 0, 0, 0);
    chk("err_head", bus.out_code, 8'h44);
    drain();
    mid_reset();
    step(1, 2'd2, 8'h45, 0, 0, 0);
    chk("err_noterm", terminate, 0);
    chk("err_cnt_noterm", err_cnt, 1);
    drain();

    // FATAL terminates regardless of term_on_err; counters untouched.
    step(1, 2'd3, 8'h55, 0, 0, 0);
    chk("fatal_term", terminate, 1);
    chk("fatal_err", err_cnt, 1);
    chk("fatal_head", bus.out_code, 8'h55);
    drain();
    repeat (3) step(1, 2'd1, 8'h56, 1, 0, 0);
    chk("fatal_sticky", terminate, 1);
    chk("fatal_empty", bus.out_valid, 0);
    mid_reset();

    // Warn counter saturation and clear-wins.
    repeat (17) step(1, 2'd1, 8'h66, 1, 0, 0);
    chk("warn_sat", warn_cnt, CMAX);
    step(1, 2'd1, 8'h67, 1, 0, 1);
    chk("warn_clr", warn_cnt, 0);
    drain();

    // Reset mid-stream with four entries queued; ts restarts at 0.
    for (int i = 0; i < 4; i++) step(1, 2'd1, 8'(8'h70 + i), 0, 0, 0);
    chk("q4_valid", bus.out_valid, 1);
    mid_reset();
    step(1, 2'd0, 8'h77, 0, 0, 0);
    chk("ts_restart", bus.out_ts, 0);
    chk("ts_restart_code", bus.out_code, 8'h77);

    // Random traffic; reset some cycles after each terminate.
    begin
      int since_term = 0;
      for (int n = 0; n < 3000; n++) begin
        int r = $urandom_range(0, 99);
        bit [1:0] sv = (r < 40) ? 2'd0 : (r < 70) ? 2'd1 : (r < 98) ? 2'd2 : 2'd3;
        step($urandom_range(0, 3) != 0, sv, 8'($urandom),
             $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
             $urandom_range(0, 29) == 0);
        if (term_m) since_term++;
        if (since_term > 12) begin
          mid_reset();
          since_term = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
